cm_sort_ser: RTL and testbench
==============================

# cm_sort_ser

Sorted-vector serializer for the `cm_sort` output interface. It accepts a full parallel vector on a valid-only strobe and buffers up to `BUF_CNT` vectors. It streams the buffered elements one per beat, index 0 first, on a valid/ready interface. Typical placement is directly after `cm_sort`, feeding narrow downstream logic that consumes the sorted order element by element.

## Interface
- `DATA_CNT`, 8: elements per vector, ≥2.
- `DATA_WIDTH`, 16: element width in bits.
- `BUF_CNT`, 2: vector buffer depth, ≥1.
- `IDX_W`, `$clog2(DATA_CNT)`: derived localparam, not overridable.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_vld`  in  1  input vector strobe. There is no backpressure; the vector is captured or dropped in the same cycle.
- `i_data`  in  `[DATA_CNT-1:0][DATA_WIDTH-1:0]`  input vector; element 0 is the smallest.
- `o_vld`  out  1  output element valid.
- `i_rdy`  in  1  downstream ready.
- `o_data`  out  `DATA_WIDTH`  current element.
- `o_idx`  out  `IDX_W`  position of the current element within its vector.
- `o_last`  out  1  final element emitted for the current vector.
- `o_ovf`  out  1  one-cycle pulse when an input vector is dropped.

## Operation
- Buffer: circular store of `BUF_CNT` vectors with write pointer, read pointer and occupancy count.
  - Capture happens when `i_vld` is high and the buffer is not full.
  - If the buffer is full and no slot frees this cycle, the vector is dropped and `o_ovf` is 1 on the next cycle.
- Slot release: a slot frees in the cycle the `o_last` beat transfers (`o_vld && i_rdy && o_last`). A write in that same cycle is accepted, so full plus a simultaneous pop does not count as overflow.
- FSM:
  - IDLE → SEND when occupancy is greater than 0; element index loads to the first emitted position.
  - In SEND, each transfer advances the index to the next emitted position.
  - On the `o_last` transfer: go to SEND for the next slot if another vector is buffered (including one written this cycle), else go to IDLE.
- Stability: `o_data`, `o_idx` and `o_last` hold stable while `o_vld && !i_rdy`.
- Input ordering: sort order is not checked. Elements are emitted in index order regardless of value.
- Reset: every output resets to 0, the FSM resets to IDLE, and pointers and count clear. Reset mid-vector discards all buffered data and the partially sent vector, with no `o_last` beat. An `i_vld` in the reset cycle is ignored.

## Timing
- Latency from capture at edge t (empty buffer, IDLE) to first element: `o_vld` = 1 in cycle t+1.
- Throughput: 1 element per cycle while `i_rdy` = 1. No bubble between the `o_last` beat of one vector and element 0 of the next buffered vector.
- A vector of N emitted elements occupies its slot for at least N cycles after first valid.
- `o_ovf` is registered: it pulses the cycle after the dropped `i_vld`, for exactly 1 cycle per dropped vector.
- Outputs are registered or driven from registered state plus buffer read. There is no combinational path from `i_vld` or `i_data` to the outputs. `i_rdy` affects only next-state.

## Configuration
- Macro `CM_SORT_SER_DEDUP_EN`.
  - **Defined:** element k is emitted only if k == 0 or `data[k] != data[k-1]`.
    - Skipped positions cost zero cycles; a priority encoder selects the next emitted index.
    - `o_idx` reports the original position of the emitted element.
    - `o_last` is set on the emitted element with no later position j where `data[j] != data[j-1]`.
    - An all-equal vector emits one beat with `o_idx` = 0 and `o_last` = 1.
  - **Undefined:** all `DATA_CNT` elements are emitted; `o_last` is set exactly when `o_idx == DATA_CNT-1`.

## Test plan
Configuration for all cases: `DATA_CNT`=4, `DATA_WIDTH`=16, `BUF_CNT`=2.

- Reset check: hold `i_rst` high 2 cycles with `i_vld` = 1 → `o_vld`, `o_ovf`, `o_last` = 0 throughout; nothing emitted after release.
- Single vector {1,2,3,4} (element 0 = 1) at t, `i_rdy` = 1 → cycles t+1..t+4 show `o_data` 1,2,3,4, `o_idx` 0..3, `o_last` only at t+4; `o_vld` = 0 at t+5.
- Backpressure, same vector, `i_rdy` = 1,0,0,1,0,1,1 → exactly 4 transfers in order; outputs stable during every stall cycle.
- Overflow: vectors A, B, C on consecutive cycles with `i_rdy` = 0 → C dropped and `o_ovf` pulses once; after `i_rdy` = 1, A then B stream as 8 back-to-back beats.
- Full plus simultaneous pop: buffer holds A and B, and the A `o_last` beat transfers in the same cycle as C's `i_vld` → C is captured, `o_ovf` stays 0, and A, B, C each emit 4 beats.
- Dedup on {5,5,7,7}:
  - With `CM_SORT_SER_DEDUP_EN`: 2 beats, (5, idx 0) then (7, idx 2, last).
  - Without it: 4 beats, last at idx 3.
- Reset mid-vector: reset after 2 beats of {1,2,3,4} with a second vector buffered → `o_vld` is 0 the cycle after reset and no further beats appear.

Source files
------------

// File: rtl/cm_sort_ser.sv
// Buffers up to BUF_CNT sorted vectors and streams them one element per beat, index 0 first; first beat one cycle after capture.
// Input is strobe-only (full buffer drops the vector, o_ovf pulses); output stalls on i_rdy; CM_SORT_SER_DEDUP_EN skips repeated elements.
module cm_sort_ser #(
  parameter int DATA_CNT   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BUF_CNT    = 2,
  localparam int IDX_W     = $clog2(DATA_CNT)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_vld,
  input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  i_data,
  output logic                                 o_vld,
  input  logic                                 i_rdy,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic [IDX_W-1:0]                     o_idx,
  output logic                                 o_last,
  output logic                                 o_ovf
);

  localparam int PTR_W = (BUF_CNT > 1) ? $clog2(BUF_CNT) : 1;
  localparam int CNT_W = $clog2(BUF_CNT + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                              state, state_nxt;
  logic [IDX_W-1:0]                    idx, idx_nxt, nxt_pos;
  logic [PTR_W-1:0]                    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]                    count;
  logic [DATA_CNT-1:0][DATA_WIDTH-1:0] mem [BUF_CNT];
  logic [DATA_CNT-1:0][DATA_WIDTH-1:0] cur;
  logic                                at_last, full, pop, wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_CNT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next emitted position within the vector at the read pointer.
  always_comb begin
    cur     = mem[rd_ptr];
`ifdef CM_SORT_SER_DEDUP_EN
    nxt_pos = idx;
    at_last = 1'b1;
    for (int j = DATA_CNT - 1; j >= 1; j--) begin
      if (IDX_W'(j) > idx && cur[j] != cur[j-1]) begin
        nxt_pos = IDX_W'(j);
        at_last = 1'b0;
      end
    end
`else
    nxt_pos = idx + IDX_W'(1);
    at_last = (idx == IDX_W'(DATA_CNT - 1));
`endif
  end

  always_comb begin
    o_vld  = (state == SEND);
    o_last = o_vld && at_last;
    o_data = o_vld ? cur[idx] : '0;
    o_idx  = idx;
    pop    = o_vld && i_rdy && at_last;
    full   = (count == CNT_W'(BUF_CNT));
    // A slot released by this cycle's last beat can take this cycle's vector.
    wr     = i_vld && (!full || pop);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (count != '0 || wr) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (i_rdy) begin
          if (at_last) begin
            idx_nxt   = '0;
            state_nxt = (count > CNT_W'(1) || wr) ? SEND : IDLE;
          end else begin
            idx_nxt = nxt_pos;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      idx    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      o_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (wr)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr) - CNT_W'(pop);
      o_ovf <= i_vld && !wr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_cm_sort_ser.sv
// Directed bench for cm_sort_ser with a beat-queue reference model and literal sequence checks.
module tb_cm_sort_ser;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NB = 2;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst, vld, rdy;
  logic [N-1:0][W-1:0] data;
  logic                o_vld, o_last, o_ovf;
  logic [W-1:0]        o_data;
  logic [1:0]          o_idx;

  int total = 0;
  int bad   = 0;

  // model state
  beat_t bq[$];
  int    vcnt = 0;
  bit    ovf_m = 0;
  bit    rst_cyc = 0;
  bit    en = 0;

  beat_t log_q[$];
  int    ovf_seen = 0;

  cm_sort_ser #(.DATA_CNT(N), .DATA_WIDTH(W), .BUF_CNT(NB)) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_data(data),
    .o_vld(o_vld), .i_rdy(rdy), .o_data(o_data), .o_idx(o_idx),
    .o_last(o_last), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int d, input int i, input bit l);
    beat_t b;
    b.d = W'(d);
    b.idx = 2'(i);
    b.last = l;
    return b;
  endfunction

  // Expected emitted beats for one vector.
  task automatic push_vec(input logic [N-1:0][W-1:0] v);
    int pos[$];
    for (int k = 0; k < N; k++) begin
`ifdef CM_SORT_SER_DEDUP_EN
      if (k == 0 || v[k] != v[k-1]) pos.push_back(k);
`else
      pos.push_back(k);
`endif
    end
    foreach (pos[i]) bq.push_back(mk(int'(v[pos[i]]), pos[i], i == pos.size() - 1));
  endtask

  always @(posedge clk) begin
    bit pop, poplast;
    int vb;
    en      = 1;
    pop     = (bq.size() > 0) && rdy;
    poplast = pop && bq[0].last;
    vb      = vcnt;
    ovf_m   = 0;
    rst_cyc = 0;
    if (rst) begin
      bq.delete();
      vcnt    = 0;
      rst_cyc = 1;
    end else begin
      if (pop) begin
        void'(bq.pop_front());
        if (poplast) vcnt--;
      end
      if (vld) begin
        if (vb < NB || poplast) begin
          push_vec(data);
          vcnt++;
        end else begin
          ovf_m = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("o_vld", 32'(o_vld), 32'(bq.size() > 0));
      chk("o_ovf", 32'(o_ovf), 32'(ovf_m));
      if (bq.size() > 0) begin
        chk("o_data", 32'(o_data), 32'(bq[0].d));
        chk("o_idx",  32'(o_idx),  32'(bq[0].idx));
        chk("o_last", 32'(o_last), 32'(bq[0].last));
      end
      if (rst_cyc) begin
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_idx",  32'(o_idx),  32'd0);
      end
      if (o_vld && rdy && !rst) log_q.push_back('{o_data, o_idx, o_last});
      if (o_ovf) ovf_seen++;
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [N-1:0][W-1:0] d, input bit rd);
    rst = r; vld = v; data = d; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, rd);
  endtask

  task automatic check_log(input string nm, input beat_t exp[$]);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < log_q.size()) chk({nm, "_beat"}, 32'(log_q[i]), 32'(exp[i]));
    end
    log_q.delete();
  endtask

  logic [N-1:0][W-1:0] v1234, va, vb, vc, v5577, vw;
  beat_t exp_q[$];

  initial begin
    v1234 = {16'd4, 16'd3, 16'd2, 16'd1};
    va    = {16'd13, 16'd12, 16'd11, 16'd10};
    vb    = {16'd23, 16'd22, 16'd21, 16'd20};
    vc    = {16'd33, 16'd32, 16'd31, 16'd30};
    v5577 = {16'd7, 16'd7, 16'd5, 16'd5};
    vw    = {16'd9, 16'd8, 16'd7, 16'd6};

    // reset with i_vld asserted, then nothing must appear
    cyc(1, 1, v1234, 1);
    cyc(1, 1, v1234, 1);
    idle(4, 1);
    exp_q.delete();
    check_log("reset", exp_q);

    // single vector, full rate
    cyc(0, 1, v1234, 1);
    idle(6, 1);
    exp_q = '{mk(1, 0, 0), mk(2, 1, 0), mk(3, 2, 0), mk(4, 3, 1)};
    check_log("single", exp_q);

    // backpressure pattern
    cyc(0, 1, v1234, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    idle(3, 1);
    check_log("bp", exp_q);

    // overflow: third vector dropped
    ovf_seen = 0;
    cyc(0, 1, va, 0);
    cyc(0, 1, vb, 0);
    cyc(0, 1, vc, 0);
    idle(2, 0);
    idle(12, 1);
    chk("ovf_pulses", 32'(ovf_seen), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(10 + i, i, i == 3));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(20 + i, i, i == 3));
    check_log("ovf", exp_q);

    // full buffer with simultaneous last-beat pop accepts C
    ovf_seen = 0;
    cyc(0, 1, va, 0);
    cyc(0, 1, vb, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 1, vc, 1);
    idle(12, 1);
    chk("fullpop_ovf", 32'(ovf_seen), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(10 + i, i, i == 3));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(20 + i, i, i == 3));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(30 + i, i, i == 3));
    check_log("fullpop", exp_q);

    // repeated elements
    cyc(0, 1, v5577, 1);
    idle(6, 1);
`ifdef CM_SORT_SER_DEDUP_EN
    exp_q = '{mk(5, 0, 0), mk(7, 2, 1)};
`else
    exp_q = '{mk(5, 0, 0), mk(5, 1, 0), mk(7, 2, 0), mk(7, 3, 1)};
`endif
    check_log("dedup", exp_q);

    // reset after two beats with a second vector buffered
    cyc(0, 1, v1234, 1);
    cyc(0, 1, vw, 1);
    cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 1);
    chk("post_rst_vld", 32'(o_vld), 32'd0);
    idle(8, 1);
    exp_q = '{mk(1, 0, 0), mk(2, 1, 0)};
    check_log("midrst", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
